// File: rtl/fft_r22sdf_bf_stage_pkg.sv
// ============================================================================
//  Module      : fft_r22sdf_bf_stage_pkg
//  Description : Shared R2^2 SDF definitions: delay/control-bit indices and
//                the butterfly word-reduction (scale with
//                FFT_R22SDF_BF_SCALE_EN, else saturate).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_r22sdf_bf_stage_pkg;

    localparam int RED_WIDTH = 64;

    function automatic int delay1(input int nlog2, input int stage);
        return 1 << (nlog2 - 1 - 2 * stage);
    endfunction

    function automatic int delay2(input int nlog2, input int stage);
        return 1 << (nlog2 - 2 - 2 * stage);
    endfunction

    function automatic int ctl_bit1(input int nlog2, input int stage);
        return nlog2 - 1 - 2 * stage;
    endfunction

    function automatic int ctl_bit2(input int nlog2, input int stage);
        return nlog2 - 2 - 2 * stage;
    endfunction

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [RED_WIDTH-1:0] clamp(
        input logic signed [RED_WIDTH-1:0] v,
        input int                          w
    );
        logic signed [RED_WIDTH-1:0] hi;
        logic signed [RED_WIDTH-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reduce a (w+1)-bit butterfly result back to w bits.
    function automatic logic signed [RED_WIDTH-1:0] reduce(
        input logic signed [RED_WIDTH-1:0] v,
        input int                          w
    );
`ifdef FFT_R22SDF_BF_SCALE_EN
        return clamp(v >>> 1, w);
`else
        return clamp(v, w);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_r22sdf_bf_stage_bf2.sv
// ============================================================================
//  Module      : fft_r22sdf_bf2
//  Description : One SDF radix-2 butterfly with feedback delay line, optional
//                exact -j input rotation and registered output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_r22sdf_bf2
    import fft_r22sdf_bf_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 25,
    parameter int DELAY      = 1,
    parameter bit ROT_EN     = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         ctrl,
    input  logic                         rot_sel,
    input  logic signed [DATA_WIDTH-1:0] x_re,
    input  logic signed [DATA_WIDTH-1:0] x_im,
    output logic signed [DATA_WIDTH-1:0] z_re,
    output logic signed [DATA_WIDTH-1:0] z_im
);

    localparam logic signed [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH-1:0] dl_re [DELAY];
    logic signed [DATA_WIDTH-1:0] dl_im [DELAY];
    logic signed [DATA_WIDTH-1:0] head_re, head_im;
    logic signed [DATA_WIDTH-1:0] a_re, a_im;
    logic signed [DATA_WIDTH:0]   sum_re, sum_im, dif_re, dif_im;

    // -j * (a + jb) = b - ja; negating the most negative code saturates.
    always_comb begin
        a_re = x_re;
        a_im = x_im;
        if (ROT_EN && rot_sel) begin
            a_re = x_im;
            a_im = (x_re == MIN_V) ? MAX_V : -x_re;
        end
    end

    assign head_re = dl_re[DELAY-1];
    assign head_im = dl_im[DELAY-1];
    assign sum_re  = {head_re[DATA_WIDTH-1], head_re} + {a_re[DATA_WIDTH-1], a_re};
    assign sum_im  = {head_im[DATA_WIDTH-1], head_im} + {a_im[DATA_WIDTH-1], a_im};
    assign dif_re  = {head_re[DATA_WIDTH-1], head_re} - {a_re[DATA_WIDTH-1], a_re};
    assign dif_im  = {head_im[DATA_WIDTH-1], head_im} - {a_im[DATA_WIDTH-1], a_im};

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            z_re <= '0;
            z_im <= '0;
            for (int i = 0; i < DELAY; i++) begin
                dl_re[i] <= '0;
                dl_im[i] <= '0;
            end
        end else begin
            if (ctrl) begin
                z_re     <= DATA_WIDTH'(reduce(64'(sum_re), DATA_WIDTH));
                z_im     <= DATA_WIDTH'(reduce(64'(sum_im), DATA_WIDTH));
                dl_re[0] <= DATA_WIDTH'(reduce(64'(dif_re), DATA_WIDTH));
                dl_im[0] <= DATA_WIDTH'(reduce(64'(dif_im), DATA_WIDTH));
            end else begin
                z_re     <= head_re;
                z_im     <= head_im;
                dl_re[0] <= a_re;
                dl_im[0] <= a_im;
            end
            for (int i = 1; i < DELAY; i++) begin
                dl_re[i] <= dl_re[i-1];
                dl_im[i] <= dl_im[i-1];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fft_r22sdf_bf_stage.sv
// ============================================================================
//  Module      : fft_r22sdf_bf_stage
//  Description : Radix-2^2 SDF stage: BF2I, then BF2II with trivial -j
//                rotation, plus aligned counter. Macro FFT_R22SDF_BF_SCALE_EN
//                selects divide-by-2 per butterfly instead of saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_r22sdf_bf_stage
    import fft_r22sdf_bf_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 25,
    parameter int FFT_N      = 1024,
    parameter int NLOG2      = 10,
    parameter int STAGE      = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic [NLOG2-1:0]             ctr_i,
    input  logic signed [DATA_WIDTH-1:0] x_re_i,
    input  logic signed [DATA_WIDTH-1:0] x_im_i,
    output logic [NLOG2-1:0]             ctr_o,
    output logic signed [DATA_WIDTH-1:0] z_re_o,
    output logic signed [DATA_WIDTH-1:0] z_im_o
);

    localparam int D1 = delay1(NLOG2, STAGE);
    localparam int D2 = delay2(NLOG2, STAGE);
    localparam int B1 = ctl_bit1(NLOG2, STAGE);
    localparam int B2 = ctl_bit2(NLOG2, STAGE);

    if (FFT_N != (1 << NLOG2) || (NLOG2 % 2) != 0) begin : g_param_check
        $error("fft_r22sdf_bf_stage: FFT_N must equal 2**NLOG2 with NLOG2 even");
    end

    // c1_pipe[D1] lines up with BF2I output; co_pipe[D2] with BF2II output.
    logic [NLOG2-1:0]             c1_pipe [D1+1];
    logic [NLOG2-1:0]             co_pipe [D2+1];
    logic [NLOG2-1:0]             c1;
    logic signed [DATA_WIDTH-1:0] s1_re, s1_im;

    assign c1    = c1_pipe[D1];
    assign ctr_o = co_pipe[D2];

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            for (int i = 0; i <= D1; i++) c1_pipe[i] <= '0;
            for (int i = 0; i <= D2; i++) co_pipe[i] <= '0;
        end else begin
            c1_pipe[0] <= ctr_i;
            for (int i = 1; i <= D1; i++) c1_pipe[i] <= c1_pipe[i-1];
            co_pipe[0] <= c1;
            for (int i = 1; i <= D2; i++) co_pipe[i] <= co_pipe[i-1];
        end
    end

    fft_r22sdf_bf2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .DELAY      (D1),
        .ROT_EN     (1'b0)
    ) u_bf2i (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .ctrl    (ctr_i[B1]),
        .rot_sel (1'b0),
        .x_re    (x_re_i),
        .x_im    (x_im_i),
        .z_re    (s1_re),
        .z_im    (s1_im)
    );

    fft_r22sdf_bf2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .DELAY      (D2),
        .ROT_EN     (1'b1)
    ) u_bf2ii (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .ctrl    (c1[B2]),
        .rot_sel (c1[B1] & c1[B2]),
        .x_re    (s1_re),
        .x_im    (s1_im),
        .z_re    (z_re_o),
        .z_im    (z_im_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_fft_r22sdf_bf_stage.sv
// ============================================================================
//  Module      : tb_fft_r22sdf_bf_stage
//  Description : Three stage instances (N=16) against a block-level R2^2
//                reference model; honours FFT_R22SDF_BF_SCALE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_r22sdf_bf_stage;

    localparam int NI        = 3;
    localparam int LATS [NI] = '{5, 5, 14};
    localparam int D2S  [NI] = '{1, 1, 4};
    localparam int WS   [NI] = '{16, 8, 12};
`ifdef FFT_R22SDF_BF_SCALE_EN
    localparam longint DC100_A = 100;
    localparam longint NEG1_A  = -1;
    localparam longint JRE [4] = '{50, 0, 25, 25};
    localparam longint JIM [4] = '{0, 0, -25, 25};
`else
    localparam longint DC100_A = 400;
    localparam longint NEG1_A  = -4;
    localparam longint JRE [4] = '{200, 0, 100, 100};
    localparam longint JIM [4] = '{0, 0, -100, 100};
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] ctr_i = '0;
    always #5 clk = ~clk;

    longint x_re [NI];
    longint x_im [NI];
    longint h_re [NI][0:4095];
    longint h_im [NI][0:4095];
    longint o_re [NI];
    longint o_im [NI];
    longint o_ctr [NI];
    longint dc_val [NI];
    int k = 0;
    int n_vec = 0;
    int n_err = 0;

    logic signed [15:0] a_xr, a_xi, a_zr, a_zi;
    logic signed [7:0]  b_xr, b_xi, b_zr, b_zi;
    logic signed [11:0] c_xr, c_xi, c_zr, c_zi;
    logic [3:0] a_co, b_co, c_co;

    assign a_xr = 16'(x_re[0]);
    assign a_xi = 16'(x_im[0]);
    assign b_xr = 8'(x_re[1]);
    assign b_xi = 8'(x_im[1]);
    assign c_xr = 12'(x_re[2]);
    assign c_xi = 12'(x_im[2]);

    always_comb begin
        o_re[0] = longint'(a_zr); o_im[0] = longint'(a_zi); o_ctr[0] = longint'(a_co);
        o_re[1] = longint'(b_zr); o_im[1] = longint'(b_zi); o_ctr[1] = longint'(b_co);
        o_re[2] = longint'(c_zr); o_im[2] = longint'(c_zi); o_ctr[2] = longint'(c_co);
    end

    fft_r22sdf_bf_stage #(.DATA_WIDTH(16), .FFT_N(16), .NLOG2(4), .STAGE(1)) dut_a (
        .clk_i(clk), .rst_n(rst_n), .ctr_i(ctr_i), .x_re_i(a_xr), .x_im_i(a_xi),
        .ctr_o(a_co), .z_re_o(a_zr), .z_im_o(a_zi));
    fft_r22sdf_bf_stage #(.DATA_WIDTH(8), .FFT_N(16), .NLOG2(4), .STAGE(1)) dut_b (
        .clk_i(clk), .rst_n(rst_n), .ctr_i(ctr_i), .x_re_i(b_xr), .x_im_i(b_xi),
        .ctr_o(b_co), .z_re_o(b_zr), .z_im_o(b_zi));
    fft_r22sdf_bf_stage #(.DATA_WIDTH(12), .FFT_N(16), .NLOG2(4), .STAGE(0)) dut_c (
        .clk_i(clk), .rst_n(rst_n), .ctr_i(ctr_i), .x_re_i(c_xr), .x_im_i(c_xi),
        .ctr_o(c_co), .z_re_o(c_zr), .z_im_o(c_zi));

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (k=%0d): got %0d expected %0d", tag, k, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic longint red(input longint v, input int w);
`ifdef FFT_R22SDF_BF_SCALE_EN
        return v >>> 1;
`else
        return sat(v, w);
`endif
    endfunction

    // Output m of a length-4*D2 block: radix-4 DFT (two radix-2 passes) over
    // the four inputs spaced D2 apart, with -j applied to the fourth partial.
    function automatic void model(input int i, input int n, output longint er, output longint ei);
        int d2, w, m, q, r, n0;
        longint xr [4], xi [4], ur [4], ui [4];
        longint tr, ti;
        d2 = D2S[i];
        w  = WS[i];
        m  = n % (4 * d2);
        q  = m / d2;
        r  = m % d2;
        n0 = n - m;
        for (int p = 0; p < 4; p++) begin
            xr[p] = h_re[i][n0 + r + d2 * p];
            xi[p] = h_im[i][n0 + r + d2 * p];
        end
        ur[0] = red(xr[0] + xr[2], w); ui[0] = red(xi[0] + xi[2], w);
        ur[1] = red(xr[1] + xr[3], w); ui[1] = red(xi[1] + xi[3], w);
        ur[2] = red(xr[0] - xr[2], w); ui[2] = red(xi[0] - xi[2], w);
        ur[3] = red(xr[1] - xr[3], w); ui[3] = red(xi[1] - xi[3], w);
        tr = ui[3];
        ti = sat(-ur[3], w);
        case (q)
            0:       begin er = red(ur[0] + ur[1], w); ei = red(ui[0] + ui[1], w); end
            1:       begin er = red(ur[0] - ur[1], w); ei = red(ui[0] - ui[1], w); end
            2:       begin er = red(ur[2] + tr, w);    ei = red(ui[2] + ti, w);    end
            default: begin er = red(ur[2] - tr, w);    ei = red(ui[2] - ti, w);    end
        endcase
    endfunction

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int n;
            longint er, ei, ec;
            n = k - LATS[i];
            if (n < 0) begin
                er = 0; ei = 0; ec = 0;
            end else begin
                model(i, n, er, ei);
                ec = longint'(n % 16);
            end
            check($sformatf("z_re[%0d]", i), o_re[i], er);
            check($sformatf("z_im[%0d]", i), o_im[i], ei);
            check($sformatf("ctr_o[%0d]", i), o_ctr[i], ec);
        end
    endtask

    // mode 0: DC dc_val, mode 1: 100 while ctr[1]==0, mode 2: full-range random
    task automatic step(input int mode);
        for (int i = 0; i < NI; i++) begin
            case (mode)
                0: begin x_re[i] = dc_val[i]; x_im[i] = 0; end
                1: begin x_re[i] = ((k & 2) == 0) ? 100 : 0; x_im[i] = 0; end
                default: begin
                    x_re[i] = longint'($urandom_range(0, (1 << WS[i]) - 1)) - (longint'(1) << (WS[i] - 1));
                    x_im[i] = longint'($urandom_range(0, (1 << WS[i]) - 1)) - (longint'(1) << (WS[i] - 1));
                end
            endcase
            h_re[i][k] = x_re[i];
            h_im[i][k] = x_im[i];
        end
        ctr_i = 4'(k);
        @(posedge clk);
        k++;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        ctr_i = 4'(k);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < NI; i++) begin
                x_re[i] = 55 + i;
                x_im[i] = -33;
            end
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                check($sformatf("rst_re[%0d]", i), o_re[i], 0);
                check($sformatf("rst_im[%0d]", i), o_im[i], 0);
                check($sformatf("rst_ctr[%0d]", i), o_ctr[i], 0);
            end
            ctr_i = ctr_i + 4'd1;
        end
        rst_n = 1'b1;
        k = 0;
        ctr_i = '0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            x_re[i] = 0;
            x_im[i] = 0;
        end
        do_reset(5);

        dc_val = '{100, 127, 100};
        for (int c = 0; c < 48; c++) begin
            step(0);
            if (k >= LATS[0]) begin
                check("dc100_a", o_re[0], (((k - LATS[0]) % 4) == 0) ? DC100_A : 0);
                check("sat127_b", o_re[1], (((k - LATS[1]) % 4) == 0) ? 127 : 0);
            end
        end

        do_reset(1);
        dc_val = '{-1, -128, -1};
        for (int c = 0; c < 32; c++) begin
            step(0);
            if (k >= LATS[0]) begin
                check("neg1_a", o_re[0], (((k - LATS[0]) % 4) == 0) ? NEG1_A : 0);
                check("sat128_b", o_re[1], (((k - LATS[1]) % 4) == 0) ? -128 : 0);
            end
        end

        do_reset(1);
        for (int c = 0; c < 32; c++) begin
            step(1);
            if (k >= LATS[0]) begin
                check("negj_re", o_re[0], JRE[(k - LATS[0]) % 4]);
                check("negj_im", o_im[0], JIM[(k - LATS[0]) % 4]);
            end
        end

        // Random stream cut by a one-cycle reset at ctr_i = 7, then DC restart.
        do_reset(1);
        for (int c = 0; c < 7; c++) step(2);
        do_reset(1);
        dc_val = '{100, 100, 100};
        for (int c = 0; c < 48; c++) begin
            step(0);
            if (k >= LATS[0])
                check("restart_a", o_re[0], (((k - LATS[0]) % 4) == 0) ? DC100_A : 0);
        end

        do_reset(1);
        for (int c = 0; c < 400; c++) step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
